mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU port (0) and the loader port (1).
// last = 1 means port 1 was granted most recently, so port 0 wins a contention.
module mem_arb_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester always wins, a tie goes to the port not served last.
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// One transaction per three cycles: IDLE (request sampled), ACCESS (grant, address
// and write strobe on the memory), RESP (memory read data returns), then the read
// data is registered so rvalid appears in the following cycle.
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin contention handling;
// without it port 0 always wins a tie and no pointer register is built.
//
// state  | meaning
// IDLE   | waiting for a request; a request here is accepted and granted
// ACCESS | memory address/write data presented, gnt pulses, write strobe if a write
// RESP   | memory read data valid; captured into the owner's rdata for reads
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic              owner_q, owner_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        pick;
    logic              pick_last;

    mem_arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (pick_last),
        .grant (pick)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_q;

    assign pick_last = last_q;

    // Remember which port was granted last; reset favours port 0 on the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && pick != 2'b00) begin
            last_q <= pick[1];
        end
    end
`else
    assign pick_last = 1'b1;
`endif

    // State register and all registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data registers hold.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        rd_d     = rd_q;
        owner_d  = owner_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ACCESS;
                    gnt_d   = pick;
                    owner_d = pick[1];
                    addr_d  = pick[1] ? addr1 : addr0;
                    wdata_d = pick[1] ? wdata1 : wdata0;
                    we_d    = pick[1] ? we1 : we0;
                    rd_d    = pick[1] ? !we1 : !we0;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (rd_q) begin
                    rvalid_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = mem_data_out;
                    end else begin
                        rdata0_d = mem_data_out;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0         = gnt_q[0];
    assign gnt1         = gnt_q[1];
    assign rvalid0      = rvalid_q[0];
    assign rvalid1      = rvalid_q[1];
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign busy         = (state_q != IDLE);
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_write_en = we_q;

endmodule
